pipe_result_collector: RTL and testbench

Receive-side companion to the 3-stage arithmetic pipeline. The pipeline has no stall and no valid signal, so this block tracks issue strobes through a latency-matched tag shift register. It captures the pipeline output `f` on the exact cycle each issued result emerges and buffers results in a first-word-fall-through FIFO with a valid/ready output. Credit-based `in_ready` stops the issuer from having more results outstanding than the FIFO can hold, so no result is lost while downstream stalls.

---
 rtl/pipe_result_collector_if.sv | 27 ++
 rtl/pipe_result_collector.sv | 73 +++++++
 tb/tb_pipe_result_collector.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_result_collector_if.sv
// Issue/result handshake bundle between issuer, pipeline output, collector and consumer.
// The collector takes the slave modport; the issuer/consumer side takes master.
interface pipe_result_collector_if #(
  parameter int N     = 10,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  f_in;
  logic [N-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] level;
  logic          err_drop;

  modport master (
    output in_valid, f_in, out_ready,
    input  in_ready, out_data, out_valid, level, err_drop
  );

  modport slave (
    input  in_valid, f_in, out_ready,
    output in_ready, out_data, out_valid, level, err_drop
  );
endinterface

// File: rtl/pipe_result_collector.sv
// Captures results of a stall-free LAT-stage pipeline into a FWFT FIFO; issue-to-output LAT+1 edges.
// Credit-based in_ready caps buffered + in-flight results at DEPTH, so a downstream stall never loses data.
module pipe_result_collector #(
  parameter int N     = 10,
  parameter int DEPTH = 4,
  parameter int LAT   = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  pipe_result_collector_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [LAT-1:0] tag;
  logic [N-1:0]   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [LW-1:0]  level_q;
  logic           err_q;
  logic [31:0]    outstanding;
  logic           accept;
  logic           push;
  logic           pop;
  logic           not_empty;

  // Buffered entries plus results still travelling down the pipeline.
  always_comb begin
    outstanding = 32'(level_q);
    for (int i = 0; i < LAT; i++) begin
      outstanding = outstanding + 32'(tag[i]);
    end
  end

  assign bus.in_ready = (outstanding < 32'(DEPTH));
  assign accept       = bus.in_valid & bus.in_ready;
  assign push         = tag[LAT-1];
  assign not_empty    = (level_q != '0);
  assign pop          = not_empty & bus.out_ready;

  assign bus.out_valid = not_empty;
  assign bus.out_data  = not_empty ? mem[rd_ptr] : '0;
  assign bus.level     = level_q;
  assign bus.err_drop  = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      tag[0] <= accept;
      for (int i = 1; i < LAT; i++) begin
        tag[i] <= tag[i-1];
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (bus.in_valid && !bus.in_ready) err_q <= 1'b1;
    end
  end

  // Storage is not reset; out_data is masked while empty instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.f_in;
  end
endmodule

// File: tb/tb_pipe_result_collector.sv
// Directed bench: a 3-register stand-in pipeline (f = a*c + b - 2*d, 10-bit) feeds the collector.
module tb_pipe_result_collector;
  logic clk = 1'b0;
  logic rst_n;
  int   a, b, c, d;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [9:0] s1, s2, f;

  always #5 clk = ~clk;

  pipe_result_collector_if #(.N(10), .DEPTH(4)) bus ();

  pipe_result_collector #(.N(10), .DEPTH(4), .LAT(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always @(posedge clk) begin
    s1 <= 10'(a * c + b - 2 * d);
    s2 <= s1;
    f  <= s2;
  end
  assign bus.f_in = f;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int ia, input int ib, input int ic, input int id);
    a = ia; b = ib; c = ic; d = id;
  endtask

  task automatic issue(input int ia, input int ib, input int ic, input int id);
    set_ops(ia, ib, ic, id);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  int exp_q[10];
  int issued, recv, cyc;

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    set_ops(0, 0, 0, 0);
    tick();
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data",  32'(bus.out_data), 0);
    check("rst_level",     32'(bus.level), 0);
    check("rst_in_ready",  32'(bus.in_ready), 1);
    check("rst_err_drop",  32'(bus.err_drop), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single result: 3*10 + 4 - 4 = 30
    bus.out_ready = 1'b1;
    issue(3, 4, 10, 2);
    set_ops(0, 0, 0, 0);
    tick();
    tick();
    check("single_e2_valid", 32'(bus.out_valid), 0);
    tick();
    check("single_e3_valid", 32'(bus.out_valid), 1);
    check("single_e3_data",  32'(bus.out_data), 30);
    check("single_e3_level", 32'(bus.level), 1);
    tick();
    check("single_e4_valid", 32'(bus.out_valid), 0);
    check("single_e4_level", 32'(bus.level), 0);

    // Backpressure: results 7, 25, 64, 976 (2000 wraps mod 1024)
    bus.out_ready = 1'b0;
    issue(2, 1, 3, 0);
    issue(5, 2, 5, 1);
    issue(7, 3, 9, 1);
    issue(100, 0, 20, 0);
    check("bp_in_ready_low", 32'(bus.in_ready), 0);
    check("bp_level_1",      32'(bus.level), 1);
    issue(1, 1, 1, 0);
    check("bp_err_drop", 32'(bus.err_drop), 1);
    set_ops(0, 0, 0, 0);
    repeat (4) tick();
    check("bp_level_full", 32'(bus.level), 4);
    check("bp_head",       32'(bus.out_data), 7);
    check("bp_in_ready",   32'(bus.in_ready), 0);

    // Drain in issue order; the rejected fifth result never appears
    bus.out_ready = 1'b1;
    tick();
    check("drain_level3",   32'(bus.level), 3);
    check("drain_data1",    32'(bus.out_data), 25);
    check("drain_in_ready", 32'(bus.in_ready), 1);
    tick();
    check("drain_data2", 32'(bus.out_data), 64);
    tick();
    check("drain_data3", 32'(bus.out_data), 976);
    check("drain_level1", 32'(bus.level), 1);
    tick();
    check("drain_empty", 32'(bus.out_valid), 0);
    check("drain_level0", 32'(bus.level), 0);

    // Simultaneous push and pop with 3 buffered and 1 in flight: 12, 14, 37, 95
    bus.out_ready = 1'b0;
    issue(3, 3, 3, 0);
    issue(4, 0, 4, 1);
    issue(6, 5, 6, 2);
    issue(10, 1, 10, 3);
    set_ops(0, 0, 0, 0);
    tick();
    tick();
    check("sim_level3",   32'(bus.level), 3);
    check("sim_in_ready", 32'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    tick();
    check("sim_level_same", 32'(bus.level), 3);
    check("sim_head1",      32'(bus.out_data), 14);
    tick();
    check("sim_head2", 32'(bus.out_data), 37);
    tick();
    check("sim_head3", 32'(bus.out_data), 95);
    tick();
    check("sim_empty", 32'(bus.out_valid), 0);

    // Wrap-around: ten issues, result i = 14*i + 13, out_ready toggling
    for (int i = 0; i < 10; i++) exp_q[i] = 14 * i + 13;
    issued = 0;
    recv = 0;
    cyc = 0;
    while (recv < 10 && cyc < 300) begin
      bus.out_ready = ((cyc % 2) == 0);
      if (issued < 10 && bus.in_ready) begin
        set_ops(issued + 1, issued, 13, 0);
        bus.in_valid = 1'b1;
        issued++;
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("wrap_data%0d", recv), 32'(bus.out_data), 32'(exp_q[recv]));
        recv++;
      end
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    check("wrap_count", 32'(recv), 10);

    // Reset mid-flight with one result buffered and two in flight
    bus.out_ready = 1'b0;
    issue(9, 0, 9, 0);
    set_ops(0, 0, 0, 0);
    repeat (3) tick();
    check("rmf_level_pre", 32'(bus.level), 1);
    issue(2, 0, 2, 0);
    issue(3, 0, 3, 0);
    rst_n = 1'b0;
    #1;
    check("rmf_out_valid", 32'(bus.out_valid), 0);
    check("rmf_level",     32'(bus.level), 0);
    check("rmf_in_ready",  32'(bus.in_ready), 1);
    check("rmf_out_data",  32'(bus.out_data), 0);
    check("rmf_err_clear", 32'(bus.err_drop), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    check("rmf_no_capture", 32'(bus.out_valid), 0);
    check("rmf_level_post", 32'(bus.level), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
